// File: rtl/hdmi_period_encoder_if.sv
// Bundle of the upstream inputs and serialiser-facing outputs of hdmi_period_encoder.
// master: timing/packet generator side (drives vde/ade/sync/pix/aux); slave: encoder side.
// test_en exists only when TMDS_PATTERN_GEN_EN is defined.
interface hdmi_period_encoder_if;
    logic        vde;
    logic        ade;
    logic        hsync;
    logic        vsync;
    logic [23:0] pix_data;
    logic [11:0] aux_data;
    logic [29:0] tmds_out;
    logic [2:0]  period;
    logic        seq_err;
`ifdef TMDS_PATTERN_GEN_EN
    logic        test_en;

    modport master (output vde, ade, hsync, vsync, pix_data, aux_data, test_en,
                    input  tmds_out, period, seq_err);
    modport slave  (input  vde, ade, hsync, vsync, pix_data, aux_data, test_en,
                    output tmds_out, period, seq_err);
`else
    modport master (output vde, ade, hsync, vsync, pix_data, aux_data,
                    input  tmds_out, period, seq_err);
    modport slave  (input  vde, ade, hsync, vsync, pix_data, aux_data,
                    output tmds_out, period, seq_err);
`endif
endinterface

// File: rtl/hdmi_period_encoder.sv
// 3-channel TMDS/TERC4 encoder that inserts preambles and guard bands by delaying the data path.
// Latency: PREAMBLE_LEN+GUARD_LEN+1 cycles from inputs to tmds_out/period.
// No backpressure: one symbol per channel every cycle; illegal requests pulse seq_err and are dropped.
// Ports: clk, reset_n (async active-low), bus (slave modport: vde/ade/hsync/vsync/pix_data/aux_data in,
// tmds_out/period/seq_err out). Optional macro TMDS_PATTERN_GEN_EN adds bus.test_en (8-bit VID ramp).
module hdmi_period_encoder #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int CNT_W        = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hdmi_period_encoder_if.slave bus
);
    localparam int D    = PREAMBLE_LEN + GUARD_LEN;
    localparam int PH_W = $clog2(D + 1);

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;
    localparam logic [9:0] GB_A   = 10'b1011001100;
    localparam logic [9:0] GB_B   = 10'b0100110011;

    typedef enum logic [2:0] {
        P_CTRL = 3'd0, P_PRE = 3'd1, P_LGB = 3'd2, P_VID = 3'd3, P_DATA = 3'd4, P_TGB = 3'd5
    } period_e;

    // aux bits [1:0] are never encoded (ch0 carries sync there), so they are not delayed
    typedef struct packed {
        logic        vde;
        logic        ade;
        logic        vsync;
        logic        hsync;
        logic [9:0]  aux;
        logic [23:0] pix;
    } smp_t;

    smp_t    dly_q [D];
    smp_t    dly_d [D];
    smp_t    dly_out;
    period_e state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic    kind_vid_q, kind_vid_d;
    logic    vde_prev_q, vde_prev_d, ade_prev_q, ade_prev_d;
    logic    rise_v, rise_a;
    logic    seq_err_q, seq_err_d;
    logic [29:0] tmds_q, tmds_d;
    logic signed [CNT_W-1:0] cnt_q [3];
    logic signed [CNT_W-1:0] cnt_d [3];
    logic [7:0]  vid_pix [3];
    logic [CNT_W+9:0] enc [3];
    logic [1:0]  c0;
`ifdef TMDS_PATTERN_GEN_EN
    logic [7:0]  ramp_q, ramp_d;
`endif

    function automatic logic [3:0] popcnt8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctl_word(input logic [1:0] c);
        case (c)
            2'b00:   return CTL_00;
            2'b01:   return CTL_01;
            2'b10:   return CTL_10;
            default: return CTL_11;
        endcase
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] n);
        case (n)
            4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;  default: return 10'b1011000011;
        endcase
    endfunction

    // Returns {symbol[9:0], next running disparity}.
    function automatic logic [CNT_W+9:0] tmds_enc(input logic [7:0] d,
                                                  input logic signed [CNT_W-1:0] cnt);
        logic [3:0] n1_d, n1_m;
        logic       use_xnor, cnt_pos, cnt_neg;
        logic [8:0] q_m;
        logic [9:0] q;
        logic signed [CNT_W-1:0] bal, c;
        n1_d     = popcnt8(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
        q_m[0]   = d[0];
        for (int i = 1; i < 8; i++) q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
        q_m[8]   = ~use_xnor;
        n1_m     = popcnt8(q_m[7:0]);
        // ones minus zeros of q_m[7:0]; intermediate may wrap, result always fits
        bal      = $signed(CNT_W'({n1_m, 1'b0})) - $signed(CNT_W'(8));
        cnt_neg  = cnt[CNT_W-1];
        cnt_pos  = !cnt_neg && (cnt != '0);
        if ((cnt == '0) || (n1_m == 4'd4)) begin
            q = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            c = q_m[8] ? cnt + bal : cnt - bal;
        end else if ((cnt_pos && n1_m > 4'd4) || (cnt_neg && n1_m < 4'd4)) begin
            q = {1'b1, q_m[8], ~q_m[7:0]};
            c = cnt + $signed(CNT_W'({q_m[8], 1'b0})) - bal;
        end else begin
            q = {1'b0, q_m[8], q_m[7:0]};
            c = cnt - $signed(CNT_W'({~q_m[8], 1'b0})) + bal;
        end
        return {q, c};
    endfunction

    always_comb begin
        dly_d[0].vde   = bus.vde;
        dly_d[0].ade   = bus.ade;
        dly_d[0].vsync = bus.vsync;
        dly_d[0].hsync = bus.hsync;
        dly_d[0].aux   = bus.aux_data[11:2];
        dly_d[0].pix   = bus.pix_data;
        for (int i = 1; i < D; i++) dly_d[i] = dly_q[i-1];
        dly_out    = dly_q[D-1];
        vde_prev_d = bus.vde;
        ade_prev_d = bus.ade;
        rise_v     = bus.vde & ~vde_prev_q;
        rise_a     = bus.ade & ~ade_prev_q;
        seq_err_d  = ((rise_v | rise_a) && (state_q != P_CTRL)) || (rise_v && rise_a);

        state_d    = state_q;
        kind_vid_d = kind_vid_q;
        ph_d       = ph_q + PH_W'(1);
        case (state_q)
            P_CTRL: begin
                ph_d = '0;
                if (rise_v | rise_a) begin
                    state_d    = P_PRE;
                    kind_vid_d = rise_v;   // video wins a simultaneous rise
                end
            end
            P_PRE: if (ph_q == PH_W'(PREAMBLE_LEN - 1)) begin
                state_d = P_LGB;
                ph_d    = '0;
            end
            // the guard band ends exactly when the rising-edge sample leaves the delay line
            P_LGB: if (ph_q == PH_W'(GUARD_LEN - 1)) begin
                state_d = kind_vid_q ? P_VID : P_DATA;
                ph_d    = '0;
            end
            P_VID:  if (!dly_out.vde) state_d = P_CTRL;
            P_DATA: if (!dly_out.ade) begin
                state_d = P_TGB;
                ph_d    = '0;
            end
            P_TGB:  if (ph_q == PH_W'(GUARD_LEN - 1)) state_d = P_CTRL;
            default: state_d = P_CTRL;
        endcase

        c0 = {dly_out.vsync, dly_out.hsync};
        for (int ch = 0; ch < 3; ch++) begin
`ifdef TMDS_PATTERN_GEN_EN
            vid_pix[ch] = bus.test_en ? ramp_q : dly_out.pix[8*ch +: 8];
`else
            vid_pix[ch] = dly_out.pix[8*ch +: 8];
`endif
            enc[ch]   = tmds_enc(vid_pix[ch], cnt_q[ch]);
            cnt_d[ch] = '0;
        end
`ifdef TMDS_PATTERN_GEN_EN
        ramp_d = (state_d == P_VID) ? ramp_q + 8'd1 : 8'd0;
`endif

        tmds_d = {CTL_00, CTL_00, ctl_word(c0)};
        case (state_d)
            P_PRE: tmds_d[29:10] = {kind_vid_d ? CTL_00 : CTL_01, CTL_01};
            P_LGB: tmds_d = kind_vid_d ? {GB_A, GB_B, GB_A}
                                       : {GB_B, GB_B, terc4({2'b11, c0})};
            P_VID: for (int ch = 0; ch < 3; ch++) begin
                tmds_d[10*ch +: 10] = enc[ch][CNT_W +: 10];
                cnt_d[ch]           = $signed(enc[ch][CNT_W-1:0]);
            end
            P_DATA: tmds_d = {terc4(dly_out.aux[9:6]), terc4(dly_out.aux[5:2]),
                              terc4({dly_out.aux[1:0], c0})};
            P_TGB: tmds_d = {GB_B, GB_B, terc4({2'b11, c0})};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= P_CTRL;
            ph_q       <= '0;
            kind_vid_q <= 1'b0;
            vde_prev_q <= 1'b0;
            ade_prev_q <= 1'b0;
            seq_err_q  <= 1'b0;
            tmds_q     <= '0;
            for (int i = 0; i < D; i++) dly_q[i] <= '0;
            for (int ch = 0; ch < 3; ch++) cnt_q[ch] <= '0;
`ifdef TMDS_PATTERN_GEN_EN
            ramp_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            kind_vid_q <= kind_vid_d;
            vde_prev_q <= vde_prev_d;
            ade_prev_q <= ade_prev_d;
            seq_err_q  <= seq_err_d;
            tmds_q     <= tmds_d;
            for (int i = 0; i < D; i++) dly_q[i] <= dly_d[i];
            for (int ch = 0; ch < 3; ch++) cnt_q[ch] <= cnt_d[ch];
`ifdef TMDS_PATTERN_GEN_EN
            ramp_q     <= ramp_d;
`endif
        end
    end

    // state_q is the period of the symbol currently held in tmds_q
    assign bus.tmds_out = tmds_q;
    assign bus.period   = state_q;
    assign bus.seq_err  = seq_err_q;
endmodule
